imem_loader: RTL and testbench

Byte-stream program loader that fills the processor's 2048-word instruction memory before execution. It receives a length-prefixed byte stream (e.g. from the UART receiver), assembles little-endian 32-bit words and writes them to the instruction BRAM write port at word-aligned byte addresses. It holds the core in reset until a complete image has been written. It is the write-side counterpart of the instruction memory's read port, which indexes words with addr[12:2].

---
 rtl/processor_pkg.sv | 25 ++
 rtl/imem_loader_if.sv | 35 +++
 rtl/imem_word_assembler.sv | 40 ++++
 rtl/imem_loader.sv | 162 ++++++++++++++++
 tb/tb_imem_loader.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/processor_pkg.sv
// rtl/processor_pkg.sv - shared loader types and instruction-memory sizing
//
// Contents:
//   loader_state_t  loader FSM state encoding
//   IMEM_DEPTH      instruction memory depth in 32-bit words
//   LEN_W           width of the word count and the word index
//   LEN_ONE         unit increment at LEN_W bits
package processor_pkg;

    localparam int IMEM_DEPTH = 2048;
    localparam int LEN_W      = 16;

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream, memory write port and status bundle of the loader
//
// Signals:
//   start                        arm a load (pulse)
//   in_valid / in_data / in_ready  byte stream handshake
//   mem_we / mem_addr / mem_wdata  instruction BRAM write port
//   cpu_hold / busy / done / err   status towards the core and the host
// Modports:
//   master  stream source / memory sink / status observer
//   slave   the loader itself
interface imem_loader_if #(
    parameter int ADDR_W = 32
) ();
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, err
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, err
    );
endinterface

// File: rtl/imem_word_assembler.sv
// rtl/imem_word_assembler.sv - packs little-endian bytes into 32-bit words
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   clear        restart at lane 0 (takes priority over byte_valid)
//   byte_valid   byte_data is accepted this cycle
//   byte_data    incoming byte, written to lane byte_cnt
//   word         assembled word register (lane 0 = bits [7:0])
//   byte_cnt     next lane to be filled
//   word_valid   one-cycle pulse the cycle after lane 3 was filled
module imem_word_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic [1:0]  byte_cnt,
    output logic        word_valid
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word       <= 32'd0;
            byte_cnt   <= 2'd0;
            word_valid <= 1'b0;
        end else if (clear) begin
            byte_cnt   <= 2'd0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= byte_valid && (byte_cnt == 2'd3);
            if (byte_valid) begin
                word[{byte_cnt, 3'b000} +: 8] <= byte_data;
                // 2-bit counter wraps back to lane 0 after the 4th byte
                byte_cnt <= byte_cnt + 2'd1;
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - length-prefixed byte-stream loader for the instruction memory
//
// Parameters:
//   DEPTH   instruction memory depth in words; longer images go to ERR
//   ADDR_W  width of the byte address driven to memory
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   bus         imem_loader_if.slave: start, byte stream (in_valid/in_data/in_ready),
//               BRAM write port (mem_we/mem_addr/mem_wdata), status
//               (cpu_hold/busy/done/err); every output is a register
module imem_loader
    import processor_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    imem_loader_if.slave  bus
);

    localparam logic [LEN_W:0] DEPTH_LIM = (LEN_W + 1)'(DEPTH);

    loader_state_t     state_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  word_idx_q;
    logic              in_ready_q;
    logic              cpu_hold_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [ADDR_W-1:0] mem_addr_q;

    logic              xfer;
    logic [LEN_W-1:0]  len_full;
    logic              asm_clear;
    logic              asm_valid;
    logic [31:0]       asm_word;
    logic [1:0]        asm_byte_cnt;
    logic              asm_word_valid;

    assign xfer      = bus.in_valid && in_ready_q;
    // Word count as it becomes complete with the high byte on the bus
    assign len_full  = {bus.in_data, len_q[7:0]};
    assign asm_clear = (state_q == LEN_HI) && xfer;
    assign asm_valid = (state_q == DATA) && xfer;

    imem_word_assembler u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (asm_clear),
        .byte_valid (asm_valid),
        .byte_data  (bus.in_data),
        .word       (asm_word),
        .byte_cnt   (asm_byte_cnt),
        .word_valid (asm_word_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            len_q      <= '0;
            word_idx_q <= '0;
            in_ready_q <= 1'b0;
            cpu_hold_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q    <= LEN_LO;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                LEN_LO: begin
                    if (xfer) begin
                        len_q[7:0] <= bus.in_data;
                        state_q    <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (xfer) begin
                        len_q[15:8] <= bus.in_data;
                        word_idx_q  <= '0;
                        if (len_full == '0) begin
                            state_q    <= DONE;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                        end else if ({1'b0, len_full} > DEPTH_LIM) begin
                            state_q    <= ERR;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            err_q      <= 1'b1;
                        end else begin
                            state_q <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer && (asm_byte_cnt == 2'd3)) begin
                        // Address is captured here so it is stable for the WRITE cycle
                        state_q    <= WRITE;
                        in_ready_q <= 1'b0;
                        mem_addr_q <= {{(ADDR_W - LEN_W - 2){1'b0}}, word_idx_q, 2'b00};
                    end
                end
                WRITE: begin
                    if (word_idx_q + LEN_ONE == len_q) begin
                        // Index is left on the last word so it never reaches DEPTH
                        state_q    <= DONE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        cpu_hold_q <= 1'b0;
                    end else begin
                        word_idx_q <= word_idx_q + LEN_ONE;
                        state_q    <= DATA;
                        in_ready_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.start) begin
                        state_q    <= LEN_LO;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        cpu_hold_q <= 1'b1;
                    end
                end
                ERR: begin
                    if (bus.start) begin
                        state_q    <= LEN_LO;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        err_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                    cpu_hold_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_we    = asm_word_valid;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = asm_word;
    assign bus.cpu_hold  = cpu_hold_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;
    import processor_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(32)) bus ();

    imem_loader #(.DEPTH(2048), .ADDR_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int we_cnt = 0;
    int done_cnt = 0;
    int addr_bad = 0;
    int done_cyc = 0;
    int xfer_cyc = 0;
    logic [31:0] last_addr = 32'd0;
    logic [31:0] last_data = 32'd0;
    logic [31:0] mem [0:2047];

    always @(posedge clk) cyc <= cyc + 1;

    // Memory and status monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            mem[bus.mem_addr[12:2]] = bus.mem_wdata;
            we_cnt    = we_cnt + 1;
            last_addr = bus.mem_addr;
            last_data = bus.mem_wdata;
            if (bus.mem_addr[1:0] !== 2'b00) addr_bad = addr_bad + 1;
        end
        if (bus.done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic ready_now;
        int   n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        forever begin
            ready_now = bus.in_ready;
            step();
            if (ready_now === 1'b1) break;
            n++;
            if (n > 100) begin
                tests++;
                fails++;
                $error("FAIL send_timeout: observed in_ready low for %0d cycles expected accept", n);
                break;
            end
        end
        xfer_cyc     = cyc;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_gap(input logic [7:0] b);
        int gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) step();
        send_byte(b);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic wait_done(input int budget, input int base);
        int n;
        n = 0;
        while (done_cnt == base && n < budget) begin
            step();
            n++;
        end
        if (done_cnt == base) begin
            tests++;
            fails++;
            $error("FAIL done_timeout: observed no done in %0d cycles expected pulse", budget);
        end
    endtask

    task automatic check_reset(input string p);
        chk({p, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        chk({p, "_mem_we"},   32'(bus.mem_we),   32'd0);
        chk({p, "_mem_addr"}, bus.mem_addr,      32'd0);
        chk({p, "_wdata"},    bus.mem_wdata,     32'd0);
        chk({p, "_cpu_hold"}, 32'(bus.cpu_hold), 32'd1);
        chk({p, "_busy"},     32'(bus.busy),     32'd0);
        chk({p, "_done"},     32'(bus.done),     32'd0);
        chk({p, "_err"},      32'(bus.err),      32'd0);
    endtask

    initial begin
        int bw;
        int bd;
        int t0;
        int mism;
        logic [31:0] words [4];

        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        rst_n        = 1'b0;
        repeat (3) step();
        check_reset("rst");
        rst_n = 1'b1;
        step();

        // Two-word image
        pulse_start();
        chk("t1_busy", 32'(bus.busy), 32'd1);
        chk("t1_in_ready", 32'(bus.in_ready), 32'd1);
        chk("t1_hold", 32'(bus.cpu_hold), 32'd1);
        bw = we_cnt; bd = done_cnt;
        send_byte(8'h02);
        t0 = xfer_cyc;
        send_byte(8'h00);
        send_word(32'h0000_0013);
        send_word(32'h0010_0093);
        wait_done(20, bd);
        repeat (3) step();
        chk("t1_we_count", 32'(we_cnt - bw), 32'd2);
        chk("t1_mem0", mem[0], 32'h0000_0013);
        chk("t1_mem1", mem[1], 32'h0010_0093);
        chk("t1_last_addr", last_addr, 32'h0000_0004);
        chk("t1_done_count", 32'(done_cnt - bd), 32'd1);
        chk("t1_latency", 32'(done_cyc - t0), 32'd11);
        chk("t1_hold_low", 32'(bus.cpu_hold), 32'd0);
        chk("t1_busy_low", 32'(bus.busy), 32'd0);

        // Empty image
        pulse_start();
        chk("t2_hold_reassert", 32'(bus.cpu_hold), 32'd1);
        bw = we_cnt; bd = done_cnt;
        send_byte(8'h00);
        t0 = xfer_cyc;
        send_byte(8'h00);
        wait_done(10, bd);
        repeat (3) step();
        chk("t2_we_count", 32'(we_cnt - bw), 32'd0);
        chk("t2_done_count", 32'(done_cnt - bd), 32'd1);
        chk("t2_latency", 32'(done_cyc - t0), 32'd1);
        chk("t2_hold_low", 32'(bus.cpu_hold), 32'd0);

        // Oversize image (2049 words)
        pulse_start();
        bw = we_cnt; bd = done_cnt;
        send_byte(8'h01);
        send_byte(8'h08);
        chk("t3_err", 32'(bus.err), 32'd1);
        chk("t3_in_ready", 32'(bus.in_ready), 32'd0);
        chk("t3_hold", 32'(bus.cpu_hold), 32'd1);
        chk("t3_busy", 32'(bus.busy), 32'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        repeat (5) step();
        chk("t3_in_ready_held", 32'(bus.in_ready), 32'd0);
        chk("t3_err_sticky", 32'(bus.err), 32'd1);
        chk("t3_no_writes", 32'(we_cnt - bw), 32'd0);
        chk("t3_no_done", 32'(done_cnt - bd), 32'd0);
        bus.in_valid = 1'b0;
        pulse_start();
        chk("t3_err_cleared", 32'(bus.err), 32'd0);
        chk("t3_rearmed", 32'(bus.in_ready), 32'd1);

        // Full-size image, already armed: word i holds i
        bw = we_cnt; bd = done_cnt;
        send_byte(8'h00);
        t0 = xfer_cyc;
        send_byte(8'h08);
        for (int i = 0; i < 2048; i++) send_word(32'(i));
        wait_done(20, bd);
        step();
        chk("t4_we_count", 32'(we_cnt - bw), 32'd2048);
        chk("t4_last_addr", last_addr, 32'h0000_1FFC);
        chk("t4_last_data", last_data, 32'h0000_07FF);
        chk("t4_done_count", 32'(done_cnt - bd), 32'd1);
        chk("t4_latency", 32'(done_cyc - t0), 32'd10241);
        mism = 0;
        for (int i = 0; i < 2048; i++) if (mem[i] !== 32'(i)) mism++;
        chk("t4_contents", 32'(mism), 32'd0);
        chk("t4_addr_align", 32'(addr_bad), 32'd0);

        // Gapped stream with an ignored start in the middle
        words[0] = 32'hDEAD_BEEF;
        words[1] = 32'h1234_5678;
        words[2] = 32'hCAFE_F00D;
        words[3] = 32'h0BAD_C0DE;
        pulse_start();
        bw = we_cnt; bd = done_cnt;
        send_gap(8'h04);
        send_gap(8'h00);
        for (int w = 0; w < 4; w++) begin
            for (int k = 0; k < 4; k++) send_gap(words[w][8*k +: 8]);
            if (w == 0) begin
                pulse_start();
                chk("t5_start_ignored_busy", 32'(bus.busy), 32'd1);
                chk("t5_start_ignored_hold", 32'(bus.cpu_hold), 32'd1);
            end
        end
        wait_done(20, bd);
        step();
        chk("t5_we_count", 32'(we_cnt - bw), 32'd4);
        chk("t5_mem0", mem[0], 32'hDEAD_BEEF);
        chk("t5_mem1", mem[1], 32'h1234_5678);
        chk("t5_mem2", mem[2], 32'hCAFE_F00D);
        chk("t5_mem3", mem[3], 32'h0BAD_C0DE);
        chk("t5_done_count", 32'(done_cnt - bd), 32'd1);

        // Reset in the middle of a load
        pulse_start();
        bw = we_cnt;
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        rst_n = 1'b0;
        step();
        check_reset("midrst");
        chk("t6_no_partial_write", 32'(we_cnt - bw), 32'd0);
        rst_n = 1'b1;
        step();
        pulse_start();
        bw = we_cnt; bd = done_cnt;
        send_byte(8'h01);
        send_byte(8'h00);
        send_word(32'hA5A5_5A5A);
        wait_done(20, bd);
        step();
        chk("t6_mem0", mem[0], 32'hA5A5_5A5A);
        chk("t6_we_count", 32'(we_cnt - bw), 32'd1);
        chk("t6_done_count", 32'(done_cnt - bd), 32'd1);
        chk("t6_hold_low", 32'(bus.cpu_hold), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
